// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared types, constants and the digit blanking rule for seg_scan_ctrl
//   state_t  : scan FSM states
//   is_blank : 1 when a digit must show no segments (invalid BCD or leading zero)
package seg_scan_pkg;

   typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

   localparam int         BCD_MAX    = 9;
   localparam logic [6:0] SEG_OFF    = 7'h00;
   localparam int         MAX_DIGITS = 8;

   // digits is zero-extended to MAX_DIGITS, so absent upper digits count as zeros
   function automatic logic is_blank(input logic [4*MAX_DIGITS-1:0] digits,
                                     input logic [2:0] idx, input logic lzb);
      logic lz;
      lz = 1'b1;
      for (int j = 0; j < MAX_DIGITS; j++)
         if (j >= int'(idx) && digits[4*j +: 4] != 4'd0) lz = 1'b0;
      return (digits[4*idx +: 4] > 4'(BCD_MAX)) || (lzb && idx != 3'd0 && lz);
   endfunction

endpackage

// File: rtl/scan_timer.sv
// scan_timer: down-counter with load and terminal count, times blank and dwell periods
//   load_i/val_i : reload the counter with val_i
//   tc_o         : counter is zero (last cycle of the current period)
module scan_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] val_i,
   output logic         tc_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb cnt_d = load_i ? val_i : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);

   always_ff @(posedge clk or posedge rst)
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;

   assign tc_o = cnt_q == '0;

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed common-anode seven-segment scan controller
//   en, lzb_en                       : scan enable, leading-zero blanking
//   load_valid/load_ready/load_data  : display update handshake, applied at frame boundaries
//   bcd_out -> external decoder -> seg_in, registered onto seg_out
//   an (active-low anodes), frame_done (end-of-frame pulse), err (sticky invalid digit)
module seg_scan_ctrl
   import seg_scan_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int DWELL_CYCLES = 1000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    lzb_en,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [4*NUM_DIGITS-1:0] load_data,
   output logic [3:0]              bcd_out,
   input  logic [6:0]              seg_in,
   output logic [6:0]              seg_out,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done,
   output logic                    err
);

   localparam int IW   = $clog2(NUM_DIGITS);
   localparam int MAXC = DWELL_CYCLES > BLANK_CYCLES ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int TW   = $clog2(MAXC + 1);

   state_t                  state_q, state_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] act_q, act_d, pend_q, pend_d;
   logic                    pend_full_q, pend_full_d;
   logic                    err_q, err_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic [6:0]              seg_q, seg_d;
   logic                    tc, tmr_load, boundary, accept, promote, blank;
   logic [TW-1:0]           tmr_val;

   scan_timer #(.W(TW)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .load_i (tmr_load),
      .val_i  (tmr_val),
      .tc_o   (tc)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      boundary = 1'b0;
      if (!en) begin
         state_d = IDLE;
         idx_d   = '0;
      end else begin
         case (state_q)
            IDLE:    begin state_d = BLANK; idx_d = '0; end
            BLANK:   if (tc) state_d = DRIVE;
            DRIVE:   if (tc) begin
                        state_d  = BLANK;
                        boundary = idx_q == IW'(NUM_DIGITS - 1);
                        idx_d    = boundary ? '0 : idx_q + 1'b1;
                     end
            default: state_d = IDLE;
         endcase
      end
      // IDLE keeps the timer primed with the blank period for the next start
      tmr_load    = state_q == IDLE || tc;
      tmr_val     = state_d == DRIVE ? TW'(DWELL_CYCLES - 1) : TW'(BLANK_CYCLES - 1);
      accept      = load_valid && !pend_full_q;
      promote     = pend_full_q && (boundary || state_q == IDLE);
      pend_d      = accept ? load_data : pend_q;
      pend_full_d = accept || (pend_full_q && !promote);
      act_d       = promote ? pend_q : act_q;
      blank       = is_blank(32'(act_q), 3'(idx_q), lzb_en);
      // anodes and segments are both registered from the next state so they change together
      an_d        = '1;
      if (state_d == DRIVE) an_d[idx_d] = 1'b0;
      seg_d       = (state_d == DRIVE && !blank) ? seg_in : SEG_OFF;
      err_d       = (state_q == BLANK && state_d == DRIVE && act_q[4*idx_q +: 4] > 4'(BCD_MAX))
                    || (err_q && !accept);
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         act_q       <= '0;
         pend_q      <= '0;
         pend_full_q <= 1'b0;
         err_q       <= 1'b0;
         an_q        <= '1;
         seg_q       <= SEG_OFF;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         act_q       <= act_d;
         pend_q      <= pend_d;
         pend_full_q <= pend_full_d;
         err_q       <= err_d;
         an_q        <= an_d;
         seg_q       <= seg_d;
      end

   assign load_ready = !pend_full_q;
   assign bcd_out    = act_q[4*idx_q +: 4];
   assign seg_out    = seg_q;
   assign an         = an_q;
   assign frame_done = boundary;
   assign err        = err_q;

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for an N-digit common-anode seven-segment display.
- Shares one external combinational BCD-to-7-segment decoder across all digits:
  - presents one BCD digit per slot;
  - registers the decoded segments;
  - drives the active-low digit anodes.
- Display updates use a valid/ready handshake and are applied only at frame boundaries, so no frame shows a mix of old and new digits.

Parameters:
- NUM_DIGITS, 4: number of display digits (2..8).
- DWELL_CYCLES, 1000: cycles each digit is driven.
- BLANK_CYCLES, 16: cycles all anodes are off before each digit (anti-ghosting). Minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  scan enable.
- lzb_en  in  1  leading-zero blanking enable.
- load_valid  in  1  new display value offered.
- load_ready  out  1  controller can accept load_data.
- load_data  in  4*NUM_DIGITS  packed BCD digits; digit 0 in [3:0] is least significant.
- bcd_out  out  4  digit currently sent to the decoder.
- seg_in  in  7  decoder output for bcd_out, active-high, gfedcba.
- seg_out  out  7  registered segment drive, active-high.
- an  out  NUM_DIGITS  digit anodes, active-low (an[i]=0 lights digit i).
- frame_done  out  1  one-cycle pulse at the end of each frame.
- err  out  1  sticky flag: an invalid BCD digit (>9) was displayed.

Behaviour:
- Reset values, asynchronous:
  - state=IDLE, digit index=0, counters=0;
  - active register=0, pending register empty;
  - an = all ones, seg_out=0, bcd_out=0, frame_done=0, err=0, load_ready=1.
- FSM states: IDLE, BLANK, DRIVE.
  - IDLE: an all ones, seg_out=0. When en=1, go to BLANK with digit index=0.
  - BLANK: lasts BLANK_CYCLES.
    - an all ones, seg_out=0.
    - bcd_out = active[idx], so the decoder settles before drive.
    - Then go to DRIVE.
  - DRIVE: lasts DWELL_CYCLES.
    - an[idx]=0, all other anodes 1.
    - seg_out <= seg_in each cycle (one register stage), or 0 if the digit is blanked.
    - At the end:
      - if idx=NUM_DIGITS-1: idx wraps to 0, frame_done=1 for that last DRIVE cycle, frame boundary occurs;
      - otherwise idx+1.
      - Then go to BLANK.
- Frame length: NUM_DIGITS*(BLANK_CYCLES+DWELL_CYCLES) cycles.
- The first lit cycle of digit 0 is BLANK_CYCLES+1 cycles after the en rise is sampled; a 1-cycle anode-to-segment skew is not permitted.
- en=0 in any state: next state is IDLE, idx=0, outputs blank. Pending data is retained.
- Load handshake:
  - load_ready = pending empty. Transfer occurs when load_valid && load_ready; load_data is captured into pending.
  - At a frame boundary, or while in IDLE, a full pending register moves to active and pending empties. load_ready rises the next cycle.
  - A load accepted on the same cycle as a boundary stays pending until the next boundary.
- Blanking:
  - Invalid digit (>9): blanked (seg_out=0) in DRIVE, and err set on that digit's first DRIVE cycle.
  - err clears only on reset or on an accepted load.
  - Leading-zero blanking (lzb_en=1): a digit i>0 is blanked if active[j]==0 for all j>=i.
  - Digit 0 is never blanked by lzb; an all-zero value shows a single 0.
- Reset mid-operation: all outputs are off immediately (asynchronous) and pending is discarded.

Decomposition:
- Package seg_scan_pkg:
  - typedef state_t {IDLE, BLANK, DRIVE};
  - localparam BCD_MAX=9, SEG_OFF=7'h00;
  - function is_blank(digits, idx, lzb_en).
- Sub-module scan_timer: a down-counter with load value and terminal-count pulse, reused for both the blank and dwell periods.
- The decoder stays external.

Test Plan (NUM_DIGITS=4, DWELL_CYCLES=4, BLANK_CYCLES=2, bench-connected decoder):
1. rst pulse, then en=1, no load:
   - an = 1111 for 2 cycles, then 1110 for 4 cycles with seg_out=7'h3F;
   - sequence repeats for an=1101, 1011, 0111;
   - frame_done pulses on cycle 24.
2. Load 0x1234 mid-frame:
   - the current frame still shows 0000;
   - load_ready=0 until the boundary;
   - the next frame shows digit0 bcd_out=4 (seg 7'h66) through digit3 bcd_out=1 (seg 7'h06).
3. lzb_en=1 with active 0x0050:
   - digits 3 and 2 give seg_out=0 during DRIVE;
   - digit1 gives 7'h6D, digit0 gives 7'h3F;
   - active 0x0000 shows only digit0=7'h3F.
4. Load 0x12A4:
   - digit1 is blanked;
   - err=1 from its first DRIVE cycle and stays set;
   - a following load of 0x1111 is accepted and clears err that cycle.
5. Two back-to-back load_valid cycles (0x1111, 0x2222):
   - the first is accepted; load_ready stays 0 until the boundary;
   - the second is held and accepted the cycle after;
   - it becomes active at the following boundary.
6. Assert rst during DRIVE of digit 2 (or drop en):
   - an = 1111 and seg_out=0 immediately (next cycle for en);
   - restart begins at digit 0 with BLANK.
